// File: rtl/mux_scan_n.sv
// Registered NCH-channel, W-bit multiplexer with manual select and an auto-scan
// mode that dwells DWELL enabled cycles on each channel before moving on.

module mux_scan_n_lane #(
    parameter int          W    = 1,
    parameter int          SELW = 1,
    parameter int unsigned K    = 0
) (
    input  logic [W-1:0]    d,
    input  logic [SELW-1:0] idx,
    output logic [W-1:0]    q
);
    assign q = (idx == SELW'(K)) ? d : '0;
endmodule

module mux_scan_n #(
    parameter int NCH   = 8,
    parameter int W     = 1,
    parameter int SELW  = $clog2(NCH),
    parameter int DWELL = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NCH*W-1:0]  w,
    input  logic [SELW-1:0]   s,
    input  logic              mode,
    input  logic              en,
    output logic [W-1:0]      f,
    output logic [SELW-1:0]   sel_out,
    output logic              f_valid,
    output logic              sel_err,
    output logic              scan_wrap
);
    localparam logic [0:0] ST_MANUAL = 1'b0;
    localparam logic [0:0] ST_SCAN   = 1'b1;

    localparam int              DW         = 8;
    localparam logic [DW-1:0]   DWELL_LAST = DW'(DWELL - 1);
    localparam logic [SELW-1:0] IDX_LAST   = SELW'(NCH - 1);
    localparam logic [SELW:0]   NCH_EXT    = (SELW + 1)'(NCH);

    logic [0:0]            state_q, state_d;
    logic [SELW-1:0]       idx_q, idx_d;
    logic [DW-1:0]         dwell_q, dwell_d;
    logic [W-1:0]          f_q, f_d;
    logic [SELW-1:0]       sel_q, sel_d;
    logic                  vld_q, vld_d;
    logic                  err_q, err_d;
    logic                  wrap_q, wrap_d;

    logic [NCH-1:0][W-1:0] ch_data;
    logic [NCH-1:0][W-1:0] lane_q;
    logic [W-1:0]          rd_data;
    logic [SELW-1:0]       rd_idx;
    logic [SELW-1:0]       scan_idx;
    logic [DW-1:0]         scan_dwell;
    logic                  in_range;

    assign ch_data = w;

    // Scan counters only count while in SCAN; the first SCAN edge sees them as 0.
    assign scan_idx   = (state_q == ST_SCAN) ? idx_q   : '0;
    assign scan_dwell = (state_q == ST_SCAN) ? dwell_q : '0;
    assign rd_idx     = mode ? scan_idx : s;
    assign in_range   = ({1'b0, s} < NCH_EXT);

    for (genvar k = 0; k < NCH; k++) begin : g_lane
        mux_scan_n_lane #(
            .W    (W),
            .SELW (SELW),
            .K    (k)
        ) u_lane (
            .d   (ch_data[k]),
            .idx (rd_idx),
            .q   (lane_q[k])
        );
    end

    always_comb begin
        rd_data = '0;
        for (int k = 0; k < NCH; k++) begin
            rd_data = rd_data | lane_q[k];
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        dwell_d = dwell_q;
        f_d     = f_q;
        sel_d   = sel_q;
        vld_d   = vld_q;
        err_d   = err_q;
        wrap_d  = 1'b0;
        if (en) begin
            state_d = mode ? ST_SCAN : ST_MANUAL;
            if (mode) begin
                f_d   = rd_data;
                sel_d = scan_idx;
                vld_d = 1'b1;
                err_d = 1'b0;
                if (scan_dwell == DWELL_LAST) begin
                    dwell_d = '0;
                    if (scan_idx == IDX_LAST) begin
                        idx_d  = '0;
                        wrap_d = 1'b1;
                    end else begin
                        idx_d = scan_idx + SELW'(1);
                    end
                end else begin
                    dwell_d = scan_dwell + DW'(1);
                    idx_d   = scan_idx;
                end
            end else begin
                f_d     = in_range ? rd_data : '0;
                sel_d   = s;
                vld_d   = in_range;
                err_d   = ~in_range;
                idx_d   = '0;
                dwell_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_MANUAL;
            idx_q   <= '0;
            dwell_q <= '0;
            f_q     <= '0;
            sel_q   <= '0;
            vld_q   <= 1'b0;
            err_q   <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            dwell_q <= dwell_d;
            f_q     <= f_d;
            sel_q   <= sel_d;
            vld_q   <= vld_d;
            err_q   <= err_d;
            wrap_q  <= wrap_d;
        end
    end

    assign f         = f_q;
    assign sel_out   = sel_q;
    assign f_valid   = vld_q;
    assign sel_err   = err_q;
    assign scan_wrap = wrap_q;

endmodule
